reg_to_obi_master: RTL and testbench

Register-interface-to-OBI bridge. It accepts one `reg_pkg::reg_req_t` transaction at a time and replays it as an OBI master transaction (`obi_req_t`/`obi_resp_t`). It lets accelerator-side register agents initiate accesses onto the system OBI bus: the initiator counterpart of the slave path that converts OBI into register accesses. A bounded timeout guarantees the register side always completes, with `error=1` if the OBI slave stalls.

---
 rtl/reg_to_obi_master_pkg.sv | 48 ++++
 rtl/reg_to_obi_master.sv | 170 +++++++++++++++++
 tb/tb_reg_to_obi_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_to_obi_master_pkg.sv
// Shared types and constants for the register-interface to OBI master bridge.
// Register-interface and OBI bus types, the default abort budget, and the
// byte-enable rule.
package reg_to_obi_master_pkg;

    // Cycles allowed in the grant phase and again in the response phase.
    localparam int unsigned REG2OBI_TIMEOUT = 255;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_rsp_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Writes use the caller's strobes; reads always fetch the full word.
    function automatic logic [3:0] obi_be(input logic write, input logic [3:0] wstrb);
        logic [3:0] be;
        if (write) begin
            be = wstrb;
        end else begin
            be = 4'hF;
        end
        return be;
    endfunction

endpackage

// File: rtl/reg_to_obi_master.sv
// Register-interface to OBI master bridge. Replays one register transaction
// at a time on OBI. A timeout forces a register-side error response if the
// slave stalls. Any abandoned OBI transfer is then drained in the background
// before the next request is accepted.
module reg_to_obi_master
    import reg_to_obi_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = REG2OBI_TIMEOUT
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_req_t  reg_req_i,
    output reg_rsp_t  reg_rsp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_resp_i,
    output logic      timeout_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        DRAIN_GNT,
        DRAIN_RSP
    } state_t;

    state_t        state;
    state_t        drain_next;   // IDLE when no abandoned transfer is pending
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          timeout_hit;

    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ready;
    logic          err;
    logic [31:0]   rdata;
    logic          timeout_pulse;

    // Saturating timer step and abort condition; a zero budget never aborts.
    always_comb begin
        timer_inc   = timer;
        timeout_hit = 1'b0;
        if (timer != {TW{1'b1}}) begin
            timer_inc = timer + TW'(1);
        end else begin
            timer_inc = timer;
        end
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit = (timer == TIMER_LIMIT);
        end else begin
            timeout_hit = 1'b0;
        end
    end

    // Transaction FSM with registered OBI request and register response.
    // A handshake in the abort cycle takes priority over the timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            drain_next    <= IDLE;
            timer         <= '0;
            req           <= 1'b0;
            we            <= 1'b0;
            be            <= 4'h0;
            addr          <= 32'h0;
            wdata         <= 32'h0;
            ready         <= 1'b0;
            err           <= 1'b0;
            rdata         <= 32'h0;
            timeout_pulse <= 1'b0;
        end else begin
            ready         <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        we    <= reg_req_i.write;
                        be    <= obi_be(reg_req_i.write, reg_req_i.wstrb);
                        addr  <= reg_req_i.addr;
                        wdata <= reg_req_i.wdata;
                        timer <= '0;
                        req   <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (obi_resp_i.gnt) begin
                        req   <= 1'b0;
                        timer <= '0;
                        state <= RESP;
                    end else if (timeout_hit) begin
                        // req stays high: OBI does not allow retracting it.
                        err           <= 1'b1;
                        ready         <= 1'b1;
                        timeout_pulse <= 1'b1;
                        drain_next    <= DRAIN_GNT;
                        state         <= DONE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                RESP: begin
                    if (obi_resp_i.rvalid) begin
                        rdata <= we ? 32'h0 : obi_resp_i.rdata;
                        err   <= 1'b0;
                        ready <= 1'b1;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        err           <= 1'b1;
                        ready         <= 1'b1;
                        timeout_pulse <= 1'b1;
                        drain_next    <= DRAIN_RSP;
                        state         <= DONE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                DONE: begin
                    // An abandoned transfer may already progress in this cycle.
                    drain_next <= IDLE;
                    if ((drain_next == DRAIN_GNT) && obi_resp_i.gnt) begin
                        req   <= 1'b0;
                        state <= DRAIN_RSP;
                    end else if ((drain_next == DRAIN_RSP) && obi_resp_i.rvalid) begin
                        state <= IDLE;
                    end else begin
                        state <= drain_next;
                    end
                end
                DRAIN_GNT: begin
                    if (obi_resp_i.gnt) begin
                        req   <= 1'b0;
                        state <= DRAIN_RSP;
                    end
                end
                DRAIN_RSP: begin
                    if (obi_resp_i.rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req        <= 1'b0;
                    drain_next <= IDLE;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign obi_req_o.req   = req;
    assign obi_req_o.we    = we;
    assign obi_req_o.be    = be;
    assign obi_req_o.addr  = addr;
    assign obi_req_o.wdata = wdata;

    assign reg_rsp_o.ready = ready;
    assign reg_rsp_o.error = err;
    assign reg_rsp_o.rdata = rdata;

    assign timeout_o = timeout_pulse;

endmodule

// File: tb/tb_reg_to_obi_master.sv
// Self-checking bench for reg_to_obi_master: a reactive OBI slave with
// per-transaction grant/response delays, and a transaction-level timing model
// that predicts response cycle, error and data.
module tb_reg_to_obi_master;
    import reg_to_obi_master_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          gd;   // REQ cycles before gnt
        int          rd;   // cycles after the gnt cycle's successor until rvalid
    } txn_t;

    logic      clk;
    logic      rst;
    reg_req_t  reg_req;
    reg_rsp_t  reg_rsp;
    obi_req_t  obi_req;
    obi_resp_t obi_resp;
    logic      timeout;

    int checks;
    int failures;
    int cyc;

    txn_t        pend_q[$];
    txn_t        sq[$];
    bit          busy;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          next_free;
    logic [31:0] last_rdata;
    int          req_cnt;
    bit          rv_pend;
    int          rv_cyc;
    logic [31:0] rv_data;
    int          gap;

    reg_to_obi_master #(.TIMEOUT_CYCLES(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .reg_req_i  (reg_req),
        .reg_rsp_o  (reg_rsp),
        .obi_req_o  (obi_req),
        .obi_resp_i (obi_resp),
        .timeout_o  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] rdat,
                                input int gd, input int rd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd; t.wstrb = ws; t.rdata = rdat;
        t.gd = gd; t.rd = rd;
        return t;
    endfunction

    function automatic int rand_delay();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, 12));
    endfunction

    // Issue txn t now; the model derives acceptance and response timing.
    task automatic issue(input txn_t t);
        int  a;
        bit  grant_to;
        bit  resp_to;
        a = (cyc > next_free) ? cyc : next_free;
        grant_to = (t.gd > N);
        resp_to  = !grant_to && (t.rd > N);
        exp_err  = grant_to || resp_to;
        if (grant_to)     exp_cyc = a + N + 2;
        else if (resp_to) exp_cyc = a + 3 + t.gd + N;
        else              exp_cyc = a + 3 + t.gd + t.rd;
        next_free = exp_err ? (a + 3 + t.gd + t.rd) : (a + 4 + t.gd + t.rd);
        if (!exp_err) last_rdata = t.wr ? 32'h0 : t.rdata;
        exp_rdata = last_rdata;
        reg_req.valid = 1'b1;
        reg_req.write = t.wr;
        reg_req.addr  = t.addr;
        reg_req.wdata = t.wdata;
        reg_req.wstrb = t.wstrb;
        sq.push_back(t);
        busy = 1'b1;
    endtask

    // Run queued transactions to completion against the slave and model.
    task automatic run_stream(input int budget);
        int   limit;
        logic exp_rdy;
        limit = cyc + budget;
        gap = 0;
        while ((pend_q.size() > 0 || busy || rv_pend || sq.size() > 0) && cyc < limit) begin
            tick();
            exp_rdy = busy && (cyc == exp_cyc);
            check_value("ready", 32'(reg_rsp.ready), 32'(exp_rdy));
            check_value("timeout_o", 32'(timeout), 32'(exp_rdy && exp_err));
            if (exp_rdy) begin
                check_value("error", 32'(reg_rsp.error), 32'(exp_err));
                check_value("rdata", reg_rsp.rdata, exp_rdata);
                busy = 1'b0;
                reg_req.valid = 1'b0;
                gap = int'($urandom_range(0, 2));
            end
            obi_resp.gnt    = 1'b0;
            obi_resp.rvalid = 1'b0;
            obi_resp.rdata  = $urandom;
            if (rv_pend && cyc == rv_cyc) begin
                obi_resp.rvalid = 1'b1;
                obi_resp.rdata  = rv_data;
                rv_pend = 1'b0;
            end
            if (obi_req.req) begin
                if (sq.size() == 0) begin
                    check_value("req_spurious", 32'(obi_req.req), 32'd0);
                end else begin
                    check_value("we", 32'(obi_req.we), 32'(sq[0].wr));
                    check_value("be", 32'(obi_req.be), sq[0].wr ? 32'(sq[0].wstrb) : 32'hF);
                    check_value("addr", obi_req.addr, sq[0].addr);
                    check_value("wdata", obi_req.wdata, sq[0].wdata);
                    if (req_cnt == sq[0].gd) begin
                        obi_resp.gnt = 1'b1;
                        rv_pend = 1'b1;
                        rv_cyc  = cyc + 1 + sq[0].rd;
                        rv_data = sq[0].rdata;
                        void'(sq.pop_front());
                        req_cnt = 0;
                    end else begin
                        req_cnt++;
                    end
                end
            end
            if (!busy && pend_q.size() > 0) begin
                if (gap > 0) gap--;
                else issue(pend_q.pop_front());
            end
        end
        check_value("stream_drained", 32'(busy || pend_q.size() > 0 || rv_pend), 32'd0);
    endtask

    task automatic model_reset();
        busy = 1'b0; rv_pend = 1'b0; req_cnt = 0;
        sq.delete();
        last_rdata = 32'h0;
        next_free = cyc;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        reg_req  = '0;
        obi_resp = '0;
        tick(); tick(); tick();
        check_value("rst_obi_req", 32'(obi_req.req), 32'd0);
        check_value("rst_obi_addr", obi_req.addr, 32'd0);
        check_value("rst_obi_be", 32'(obi_req.be), 32'd0);
        check_value("rst_ready", 32'(reg_rsp.ready), 32'd0);
        check_value("rst_error", 32'(reg_rsp.error), 32'd0);
        check_value("rst_rdata", reg_rsp.rdata, 32'd0);
        check_value("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        model_reset();

        // Directed: zero wait, stalled write, timeouts, coincident edges.
        pend_q.push_back(mk(1'b0, 32'h2000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0));
        pend_q.push_back(mk(1'b1, 32'h2000_0020, 32'h1122_3344, 4'b0110, 32'h5555_AAAA, 3, 1));
        pend_q.push_back(mk(1'b0, 32'h2000_0030, 32'h0, 4'h0, 32'hAAAA_5555, 12, 2));
        pend_q.push_back(mk(1'b0, 32'h2000_0040, 32'h0, 4'h0, 32'hBAD0_BAD0, 0, 20));
        pend_q.push_back(mk(1'b0, 32'h2000_0050, 32'h0, 4'h0, 32'h1234_5678, 1, 0));
        pend_q.push_back(mk(1'b0, 32'h2000_0060, 32'h0, 4'h0, 32'hCAFE_F00D, 0, N));
        pend_q.push_back(mk(1'b1, 32'h2000_0070, 32'hA5A5_0F0F, 4'b1001, 32'h0, N, 0));
        pend_q.push_back(mk(1'b0, 32'h2000_0080, 32'h0, 4'h0, 32'h0BAD_CAFE, N + 1, 0));
        pend_q.push_back(mk(1'b0, 32'h2000_0090, 32'h0, 4'h0, 32'h7777_1111, 0, N + 1));
        pend_q.push_back(mk(1'b0, 32'h2000_00A0, 32'h0, 4'h0, 32'h2468_ACE0, 0, 0));
        run_stream(2000);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            pend_q.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                                4'($urandom_range(0, 15)), $urandom, rand_delay(), rand_delay()));
        end
        run_stream(6000);

        // Reset while a request is outstanding.
        tick();
        reg_req.valid = 1'b1; reg_req.write = 1'b0; reg_req.addr = 32'h3000_0000;
        reg_req.wdata = 32'h0; reg_req.wstrb = 4'h0;
        obi_resp = '0;
        tick();
        reg_req.valid = 1'b0;
        check_value("req_before_rst", 32'(obi_req.req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_value("req_after_rst", 32'(obi_req.req), 32'd0);
        check_value("ready_after_rst", 32'(reg_rsp.ready), 32'd0);
        rst = 1'b0;
        model_reset();
        pend_q.push_back(mk(1'b0, 32'h3000_0004, 32'h0, 4'h0, 32'hFEED_BEEF, 1, 1));
        run_stream(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
